fifo_drain_ctrl: RTL
====================

# fifo_drain_ctrl

Read-side controller for the synchronous FIFO. It pops words through the FIFO read port (`rd_en`, `data_out`, `empty`, `underflow`) and presents them on a downstream valid/ready stream at up to one word per cycle. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so backpressure never drops or duplicates data. It sits between the FIFO and any consumer, and is the drain-side counterpart to the write-side stimulus that fills the FIFO.

## Interface
- `DATA_WIDTH`, 16: word width; matches FIFO width.
- `CNT_WIDTH`, 16: width of the statistics pop counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `en`  in  1  drain enable; when low, no new FIFO reads are issued.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO underflow flag, registered, valid the cycle after a read.
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted `rd_en`.
- `fifo_rd_en`  out  1  FIFO read request (combinational).
- `m_valid`  out  1  downstream word valid.
- `m_data`  out  DATA_WIDTH  downstream word.
- `m_ready`  in  1  downstream accept.
- `pop_count`  out  CNT_WIDTH  words delivered downstream (statistics).
- `underflow_seen`  out  1  sticky: FIFO reported underflow on a read issued by this block.

## Operation
- Skid buffer is a 2-entry FIFO (head and tail registers) with occupancy `occ` in {0,1,2}. Its states are EMPTY, ONE and TWO.
- `inflight` register: set to `fifo_rd_en` on each edge, so it marks a word due on `fifo_data_out` this cycle.
- `pop` = `m_valid && m_ready`.
- `fifo_rd_en` = `rst_n && en && !fifo_empty && (occ + inflight - pop) < 2`.
- Capture: when `inflight && !fifo_underflow`, `fifo_data_out` is written to the buffer at the next edge.
  - If `inflight && fifo_underflow`, the word is discarded and `underflow_seen` is set.
- Next occupancy is `occ_next = occ + capture - pop`.
  - EMPTY→ONE on capture without pop.
  - ONE→TWO on capture without pop.
  - TWO→ONE on pop without capture.
  - ONE→EMPTY on pop without capture.
  - Capture and pop together hold the state. Head advances to tail.
- `m_valid` = (occ != 0). `m_data` = head. Order is strictly FIFO order.
- `en` falling: no new reads are issued. An in-flight word is still captured and delivered.
- `m_data` is held stable while `m_valid && !m_ready`.

## Timing
- Reset values: `occ`=0, `inflight`=0, `m_valid`=0, `m_data`=0, `pop_count`=0, `underflow_seen`=0.
  - `fifo_rd_en` is 0 while `rst_n`=0.
- Latency: `fifo_rd_en` high in cycle N gives `m_valid` in cycle N+2 when the buffer is empty.
- Throughput: 1 word/cycle sustained with `m_ready` held high.
- Backpressure: after `m_ready` drops, at most one further word is captured (buffer reaches TWO). No read is issued at TWO without a pop.
- Simultaneous capture and pop at ONE: the new word becomes head at the edge, and `m_valid` stays high.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO contents are unaffected except for a word already popped.
- `pop_count` wraps modulo 2^CNT_WIDTH.

## Configuration
- Macro: `FIFO_DRAIN_STATS_EN`.
- Defined: `pop_count` increments on each `pop`, and `underflow_seen` latches as described. Both clear only on reset.
- Undefined: no counter or sticky registers are built. `pop_count` and `underflow_seen` are tied to 0. The data path is identical.

## Structure
- Shared package holds:
  - the `DATA_WIDTH` default (shared with the FIFO);
  - `SKID_DEPTH` = 2;
  - typedef `drain_occ_t` (2-bit occupancy);
  - typedef `drain_word_t` (logic [DATA_WIDTH-1:0]).
- Sub-module `fifo_drain_skid`: the 2-entry buffer. Inputs are `wr`, `wdata` and `rd`; outputs are `occ` and `head`.
- The top level holds the rd_en credit logic, `inflight`, the underflow check and the statistics.

## Test plan
- Streaming: reset; FIFO holds 0x0001..0x0008; `en`=1 and `m_ready`=1. Required: 8 words in order on consecutive cycles, first `m_valid` 2 cycles after the first `rd_en`; `pop_count`=8; then `fifo_rd_en`=0 while empty.
- Backpressure: mid-stream, drop `m_ready` for 5 cycles. Required: `occ` reaches 2, no `rd_en` while TWO, `m_data` stable; on release, the sequence continues with no gap, loss or duplicate.
- Capture and pop at ONE: `m_ready` toggles every cycle on a 4-word FIFO. Required: words 0xA..0xD delivered in order, and `occ` never exceeds 2.
- Enable drop: `en`→0 the cycle after a `rd_en`. Required: the in-flight word is delivered, then no further reads until `en`=1.
- Reset mid-stream: assert `rst_n`=0 with `occ`=2. Required: next cycle `m_valid`=0, `pop_count`=0 and `fifo_rd_en`=0; after release, draining resumes from the FIFO's next word.
- Injected underflow: with `FIFO_DRAIN_STATS_EN`, force `fifo_underflow`=1 on an in-flight cycle. Required: the word is not delivered and `underflow_seen`=1 until reset. Without the macro, `underflow_seen` stays 0.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain controller.
// Common to fifo_drain_ctrl and fifo_drain_skid.
package fifo_drain_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int SKID_DEPTH = 2;

    typedef logic [1:0]            drain_occ_t;
    typedef logic [DATA_WIDTH-1:0] drain_word_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // A new read may be issued only if the buffer can still hold it once every
    // word already owed to it (buffered + in flight) has been counted.
    function automatic logic credit_ok(input drain_occ_t occ,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return committed < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer (head/tail registers) that absorbs the FIFO read latency.
// The head register drives the downstream data directly.
module fifo_drain_skid #(
    parameter int DATA_WIDTH = fifo_drain_pkg::DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        rd,
    output fifo_drain_pkg::drain_occ_t  occ,
    output logic [DATA_WIDTH-1:0]       head
);
    import fifo_drain_pkg::*;

    skid_state_e           state_reg;
    logic [DATA_WIDTH-1:0] head_reg;
    logic [DATA_WIDTH-1:0] tail_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= SKID_EMPTY;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            case (state_reg)
                SKID_EMPTY: begin
                    if (wr) begin
                        head_reg  <= wdata;
                        state_reg <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    case ({wr, rd})
                        2'b11: head_reg <= wdata;
                        2'b10: begin
                            tail_reg  <= wdata;
                            state_reg <= SKID_TWO;
                        end
                        2'b01: state_reg <= SKID_EMPTY;
                        default: ;
                    endcase
                end
                SKID_TWO: begin
                    // The read credit never lets a write land here without a read.
                    if (rd) begin
                        head_reg <= tail_reg;
                        if (wr) begin
                            tail_reg <= wdata;
                        end else begin
                            state_reg <= SKID_ONE;
                        end
                    end
                end
                default: state_reg <= SKID_EMPTY;
            endcase
        end
    end

    assign occ  = drain_occ_t'(state_reg);
    assign head = head_reg;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO drain controller: credit-based rd_en into a 2-entry skid buffer feeding valid/ready.
// Optional statistics (pop_count, underflow_seen) are built when FIFO_DRAIN_STATS_EN is defined.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = fifo_drain_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic                  underflow_seen
);
    import fifo_drain_pkg::*;

    drain_occ_t occ;
    logic       inflight_reg;
    logic       pop;
    logic       capture;

    assign m_valid    = (occ != 2'd0);
    assign pop        = m_valid && m_ready;
    assign fifo_rd_en = rst_n && en && !fifo_empty && credit_ok(occ, inflight_reg, pop);
    assign capture    = inflight_reg && !fifo_underflow;

    // Marks that fifo_data_out carries a word for us in the current cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= fifo_rd_en;
        end
    end

    fifo_drain_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (capture),
        .wdata (fifo_data_out),
        .rd    (pop),
        .occ   (occ),
        .head  (m_data)
    );

`ifdef FIFO_DRAIN_STATS_EN
    logic [CNT_WIDTH-1:0] pop_count_reg;
    logic                 underflow_seen_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pop_count_reg      <= '0;
            underflow_seen_reg <= 1'b0;
        end else begin
            if (pop) begin
                pop_count_reg <= pop_count_reg + CNT_WIDTH'(1);
            end
            if (inflight_reg && fifo_underflow) begin
                underflow_seen_reg <= 1'b1;
            end
        end
    end

    assign pop_count      = pop_count_reg;
    assign underflow_seen = underflow_seen_reg;
`else
    assign pop_count      = '0;
    assign underflow_seen = 1'b0;
`endif

endmodule
